first_nios2_system_sysid_arbiter: RTL and testbench

Two-master Avalon-MM read arbiter that shares the single system-ID slave between the Nios II data master and the JTAG debug master. It converts the slave's zero-latency combinational read port into a pipelined port with waitrequest and readdatavalid. The port grants one master at a time, registers the returned word, and returns it one cycle after acceptance. It sits between the interconnect and the sysid slave inside first_nios2_system.

---
 rtl/first_nios2_system_sysid_arb_pkg.sv | 23 ++
 rtl/first_nios2_system_rr_grant2.sv | 24 ++
 rtl/first_nios2_system_sysid_arbiter.sv | 125 ++++++++++++
 tb/tb_first_nios2_system_sysid_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/first_nios2_system_sysid_arb_pkg.sv
// Shared definitions for the sysid read arbiter: FSM encoding, master
// count and the values every register takes while reset_n is low.
package first_nios2_system_sysid_arb_pkg;

    localparam int NUM_MASTERS = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic RST_WAITREQUEST   = 1'b1;
    localparam logic RST_READDATAVALID = 1'b0;
    localparam logic RST_LAST_GRANT    = 1'b1;
    localparam logic RST_GRANT         = 1'b0;

    // One-hot per-master select from a grant index.
    function automatic logic [NUM_MASTERS-1:0] grant_onehot(input logic idx);
        grant_onehot = idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/first_nios2_system_rr_grant2.sv
// Two-input grant selection, purely combinational. In round-robin mode a
// tie goes to the master that was not served last; in fixed-priority mode
// master 0 always wins a tie. A single requester always wins.
module first_nios2_system_rr_grant2
    import first_nios2_system_sysid_arb_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req,
    input  logic                   last_grant,
    input  logic                   rr_mode,
    output logic                   grant
);

    // Pick the winning master index from the current requests.
    always_comb begin
        grant = 1'b0;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = rr_mode ? ~last_grant : 1'b0;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/first_nios2_system_sysid_arbiter.sv
// Two-master Avalon-MM read arbiter in front of the zero-latency sysid
// slave. Each read goes IDLE -> ACCESS -> RESP: the request is sampled in
// IDLE, accepted (waitrequest low) in ACCESS where the slave word is
// captured, and returned with a readdatavalid pulse in RESP.
// Build option: define SYSID_ARB_ROUND_ROBIN_EN for round-robin tie
// breaking; without it master 0 has fixed priority.
module first_nios2_system_sysid_arbiter
    import first_nios2_system_sysid_arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 1
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              m0_read,
    input  logic [ADDR_W-1:0] m0_address,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic              m1_read,
    input  logic [ADDR_W-1:0] m1_address,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] s_address,
    input  logic [DATA_W-1:0] s_readdata
);

`ifdef SYSID_ARB_ROUND_ROBIN_EN
    localparam logic RR_MODE = 1'b1;
`else
    localparam logic RR_MODE = 1'b0;
`endif

    state_t                  state;
    logic                    grant_idx;
    logic                    last_grant;
    logic [NUM_MASTERS-1:0]  wait_q;
    logic [NUM_MASTERS-1:0]  rdv_q;
    logic [DATA_W-1:0]       resp_q;
    logic [ADDR_W-1:0]       s_address_q;

    logic [NUM_MASTERS-1:0]  req;
    logic                    arb_grant;
    logic                    granted_read;
    logic [ADDR_W-1:0]       sel_address;

    assign req = {m1_read, m0_read};

    first_nios2_system_rr_grant2 u_grant (
        .req        (req),
        .last_grant (last_grant),
        .rr_mode    (RR_MODE),
        .grant      (arb_grant)
    );

    // Address of the master that wins this IDLE cycle, and whether the
    // master already granted is still asserting read during ACCESS.
    always_comb begin
        sel_address  = arb_grant ? m1_address : m0_address;
        granted_read = grant_idx ? m1_read : m0_read;
    end

    // FSM with registered handshake outputs, response word and grant history.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            grant_idx   <= RST_GRANT;
            last_grant  <= RST_LAST_GRANT;
            wait_q      <= {NUM_MASTERS{RST_WAITREQUEST}};
            rdv_q       <= {NUM_MASTERS{RST_READDATAVALID}};
            resp_q      <= '0;
            s_address_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    rdv_q <= '0;
                    if (|req) begin
                        grant_idx   <= arb_grant;
                        s_address_q <= sel_address;
                        wait_q      <= ~grant_onehot(arb_grant);
                        state       <= ST_ACCESS;
                    end else begin
                        wait_q <= '1;
                    end
                end
                ST_ACCESS: begin
                    wait_q <= '1;
                    if (granted_read) begin
                        resp_q <= s_readdata;
                        rdv_q  <= grant_onehot(grant_idx);
                        state  <= ST_RESP;
                    end else begin
                        // Read withdrawn while accepted: drop it silently.
                        rdv_q <= '0;
                        state <= ST_IDLE;
                    end
                end
                ST_RESP: begin
                    rdv_q      <= '0;
                    wait_q     <= '1;
                    last_grant <= grant_idx;
                    state      <= ST_IDLE;
                end
                default: begin
                    rdv_q  <= '0;
                    wait_q <= '1;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign m0_waitrequest   = wait_q[0];
    assign m1_waitrequest   = wait_q[1];
    assign m0_readdatavalid = rdv_q[0];
    assign m1_readdatavalid = rdv_q[1];
    assign m0_readdata      = resp_q;
    assign m1_readdata      = resp_q;
    assign s_address        = s_address_q;

endmodule

// File: tb/tb_first_nios2_system_sysid_arbiter.sv
// Directed bench for the sysid read arbiter with a behavioural sysid slave
// (address 0 -> 7, address 1 -> 0x5284E192).
module tb_first_nios2_system_sysid_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 1;
    localparam logic [31:0] ID0 = 32'h0000_0007;
    localparam logic [31:0] ID1 = 32'h5284_E192;

    logic              clock;
    logic              reset_n;
    logic              m0_read, m1_read;
    logic [ADDR_W-1:0] m0_address, m1_address;
    logic              m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0] m0_readdata, m1_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic [ADDR_W-1:0] s_address;
    logic [DATA_W-1:0] s_readdata;

    int n_cmp = 0;
    int n_err = 0;

    first_nios2_system_sysid_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .m0_read          (m0_read),
        .m0_address       (m0_address),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_read          (m1_read),
        .m1_address       (m1_address),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .s_address        (s_address),
        .s_readdata       (s_readdata)
    );

    assign s_readdata = (s_address == 1'b1) ? ID1 : ID0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin : stim
        logic exp_g;
        reset_n    = 1'b0;
        m0_read    = 1'b1;
        m1_read    = 1'b1;
        m0_address = 1'b0;
        m1_address = 1'b1;

        // Reset held with both masters requesting.
        repeat (5) tick();
        chk("rst_m0_wait", m0_waitrequest, 1);
        chk("rst_m1_wait", m1_waitrequest, 1);
        chk("rst_m0_rdv",  m0_readdatavalid, 0);
        chk("rst_m1_rdv",  m1_readdatavalid, 0);
        chk("rst_rdata",   m0_readdata, 0);
        chk("rst_saddr",   s_address, 0);
        reset_n = 1'b1;

        // First tie after reset goes to m0.
        tick();
        chk("tie0_m0_wait", m0_waitrequest, 0);
        chk("tie0_m1_wait", m1_waitrequest, 1);
        chk("tie0_saddr",   s_address, 0);
        tick();
        chk("tie0_m0_rdv",  m0_readdatavalid, 1);
        chk("tie0_m0_data", m0_readdata, ID0);
        chk("tie0_m1_rdv",  m1_readdatavalid, 0);
        chk("tie0_resp_m0_wait", m0_waitrequest, 1);
        m0_read = 1'b0;
        tick();
        chk("idle_m0_rdv", m0_readdatavalid, 0);
        chk("idle_m1_wait", m1_waitrequest, 1);

        // Pending m1 read of address 1.
        tick();
        chk("a1_m1_wait", m1_waitrequest, 0);
        chk("a1_m0_wait", m0_waitrequest, 1);
        chk("a1_saddr",   s_address, 1);
        tick();
        chk("a1_m1_rdv",  m1_readdatavalid, 1);
        chk("a1_m1_data", m1_readdata, ID1);
        chk("a1_m0_rdv",  m0_readdatavalid, 0);
        m1_read = 1'b0;
        tick();
        chk("a1_done_rdv", m1_readdatavalid, 0);

        // Single m0 reads back to back: one read per three cycles.
        m0_read = 1'b1;
        tick();
        chk("s1_m0_wait", m0_waitrequest, 0);
        chk("s1_m1_wait", m1_waitrequest, 1);
        tick();
        chk("s1_m0_rdv",  m0_readdatavalid, 1);
        chk("s1_m0_data", m0_readdata, ID0);
        chk("s1_m1_rdv",  m1_readdatavalid, 0);
        tick();
        chk("s2_idle_wait", m0_waitrequest, 1);
        chk("s2_idle_rdv",  m0_readdatavalid, 0);
        tick();
        chk("s2_m0_wait", m0_waitrequest, 0);
        tick();
        chk("s2_m0_rdv",  m0_readdatavalid, 1);
        chk("s2_m0_data", m0_readdata, ID0);
        m0_read = 1'b0;
        tick();

        // Continuous contention; last_grant is 0 here (m0 served last).
`ifdef SYSID_ARB_ROUND_ROBIN_EN
        exp_g = 1'b1;
`else
        exp_g = 1'b0;
`endif
        m0_read = 1'b1;
        m1_read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("cont_m0_wait", m0_waitrequest, exp_g ? 1 : 0);
            chk("cont_m1_wait", m1_waitrequest, exp_g ? 0 : 1);
            tick();
            chk("cont_m0_rdv", m0_readdatavalid, exp_g ? 0 : 1);
            chk("cont_m1_rdv", m1_readdatavalid, exp_g ? 1 : 0);
            chk("cont_data",   m0_readdata, exp_g ? ID1 : ID0);
            tick();
`ifdef SYSID_ARB_ROUND_ROBIN_EN
            exp_g = ~exp_g;
`endif
        end
        m0_read = 1'b0;
        m1_read = 1'b0;
        tick();

        // Reset asserted in the RESP cycle.
        m0_read = 1'b1;
        tick();
        chk("rr_m0_wait", m0_waitrequest, 0);
        tick();
        reset_n = 1'b0;
        #1;
        chk("rr_m0_rdv",  m0_readdatavalid, 0);
        chk("rr_m1_rdv",  m1_readdatavalid, 0);
        chk("rr_m0_wait2", m0_waitrequest, 1);
        chk("rr_rdata",   m0_readdata, 0);
        chk("rr_saddr",   s_address, 0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("rr_again_wait", m0_waitrequest, 0);
        tick();
        chk("rr_again_rdv",  m0_readdatavalid, 1);
        chk("rr_again_data", m0_readdata, ID0);
        m0_read = 1'b0;
        tick();

        // Abort: m0 withdraws its read during ACCESS, m1 is then granted.
        m0_read = 1'b1;
        tick();
        chk("ab_m0_wait", m0_waitrequest, 0);
        chk("ab_m1_wait", m1_waitrequest, 1);
        m0_read = 1'b0;
        m1_read = 1'b1;
        tick();
        chk("ab_m0_rdv",   m0_readdatavalid, 0);
        chk("ab_m1_rdv",   m1_readdatavalid, 0);
        chk("ab_m1_wait2", m1_waitrequest, 1);
        tick();
        chk("ab_m1_acc",   m1_waitrequest, 0);
        chk("ab_saddr",    s_address, 1);
        tick();
        chk("ab_m1_rdv2",  m1_readdatavalid, 1);
        chk("ab_m1_data",  m1_readdata, ID1);
        chk("ab_m0_rdv2",  m0_readdatavalid, 0);
        m1_read = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
